// File: rtl/draw_sequencer_if.sv
// Bundle of the draw sequencer's request, circle-drawer and VGA pixel signals.
// The slave view is the sequencer itself; the master view is whoever drives it.
interface draw_sequencer_if;
  logic       start;
  logic       done;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;

  logic       circ_start;
  logic [2:0] circ_colour;
  logic [7:0] circ_centre_x;
  logic [6:0] circ_centre_y;
  logic [7:0] circ_radius;
  logic       circ_done;
  logic [7:0] circ_x;
  logic [6:0] circ_y;
  logic [2:0] circ_colour_in;
  logic       circ_plot;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport slave (
    input  start, colour, centre_x, centre_y, radius,
           circ_done, circ_x, circ_y, circ_colour_in, circ_plot,
    output done, circ_start, circ_colour, circ_centre_x, circ_centre_y, circ_radius,
           vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output start, colour, centre_x, centre_y, radius,
           circ_done, circ_x, circ_y, circ_colour_in, circ_plot,
    input  done, circ_start, circ_colour, circ_centre_x, circ_centre_y, circ_radius,
           vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/draw_sequencer.sv
// Clears the 160x120 screen to black, then hands the pixel stream to a circle
// drawer with the parameters captured when the request was accepted.
module draw_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  draw_sequencer_if.slave  bus
);

  localparam logic [7:0] X_LAST = 8'd159;
  localparam logic [6:0] Y_LAST = 7'd119;

  typedef enum logic [1:0] {IDLE, CLEAR, CIRCLE, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] colour_q;
  logic [7:0] centre_x_q;
  logic [6:0] centre_y_q;
  logic [7:0] radius_q;
  logic       clear_last;

  assign clear_last = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Parameters are captured only on an accepted start; the clear scan walks
  // each column top to bottom before moving right.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx         <= '0;
      cy         <= '0;
      colour_q   <= '0;
      centre_x_q <= '0;
      centre_y_q <= '0;
      radius_q   <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        colour_q   <= bus.colour;
        centre_x_q <= bus.centre_x;
        centre_y_q <= bus.centre_y;
        radius_q   <= bus.radius;
        cx         <= '0;
        cy         <= '0;
      end
    end else if (state == CLEAR) begin
      if (cy == Y_LAST) begin
        cy <= '0;
        cx <= (cx == X_LAST) ? 8'd0 : cx + 8'd1;
      end else begin
        cy <= cy + 7'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start)     state_next = CLEAR;
      CLEAR:   if (clear_last)    state_next = CIRCLE;
      CIRCLE:  if (bus.circ_done) state_next = DONE;
      DONE:    if (!bus.start)    state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Pixel mux: black clear scan, circle drawer pass-through, otherwise idle.
  // Outputs are forced quiet while reset is held.
  always_comb begin
    bus.done       = 1'b0;
    bus.circ_start = 1'b0;
    bus.vga_x      = 8'd0;
    bus.vga_y      = 7'd0;
    bus.vga_colour = colour_q;
    bus.vga_plot   = 1'b0;
    case (state)
      CLEAR: begin
        bus.vga_x      = cx;
        bus.vga_y      = cy;
        bus.vga_colour = 3'b000;
        bus.vga_plot   = 1'b1;
      end
      CIRCLE: begin
        bus.circ_start = 1'b1;
        bus.vga_x      = bus.circ_x;
        bus.vga_y      = bus.circ_y;
        bus.vga_colour = bus.circ_colour_in;
        bus.vga_plot   = bus.circ_plot;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      bus.done       = 1'b0;
      bus.circ_start = 1'b0;
      bus.vga_x      = 8'd0;
      bus.vga_y      = 7'd0;
      bus.vga_colour = 3'b000;
      bus.vga_plot   = 1'b0;
    end
  end

  assign bus.circ_colour   = colour_q;
  assign bus.circ_centre_x = centre_x_q;
  assign bus.circ_centre_y = centre_y_q;
  assign bus.circ_radius   = radius_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: a pixel-index model of the draw
// sequence is compared against every DUT output on each falling edge.
module tb_draw_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  draw_sequencer_if dif();

  draw_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  localparam int SCREEN_PIXELS = 160 * 120;

  int tests_run    = 0;
  int tests_failed = 0;
  int clear_plots  = 0;
  bit check_en     = 1'b0;

  // Model: phase 0 idle, 1 clearing, 2 circle, 3 done; m_idx is the linear
  // clear pixel number, column-major, so x = idx/120 and y = idx%120.
  int         m_phase  = 0;
  int         m_idx    = 0;
  logic [2:0] m_colour = '0;
  logic [7:0] m_cx     = '0;
  logic [6:0] m_cy     = '0;
  logic [7:0] m_r      = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_idx = 0;
      m_colour = '0; m_cx = '0; m_cy = '0; m_r = '0;
    end else begin
      case (m_phase)
        0: if (dif.start) begin
             m_colour = dif.colour; m_cx = dif.centre_x;
             m_cy = dif.centre_y;   m_r  = dif.radius;
             m_idx = 0; m_phase = 1;
           end
        1: begin
             m_idx++;
             if (m_idx == SCREEN_PIXELS) m_phase = 2;
           end
        2: if (dif.circ_done) m_phase = 3;
        3: if (!dif.start) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [46:0] expected_outputs();
    logic       e_done, e_cs, e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
    e_done = 1'b0; e_cs = 1'b0; e_plot = 1'b0;
    e_x = '0; e_y = '0; e_col = m_colour;
    case (m_phase)
      1: begin
           e_x = 8'(m_idx / 120); e_y = 7'(m_idx % 120);
           e_col = 3'b000; e_plot = 1'b1;
         end
      2: begin
           e_cs = 1'b1; e_x = dif.circ_x; e_y = dif.circ_y;
           e_col = dif.circ_colour_in; e_plot = dif.circ_plot;
         end
      3: e_done = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      e_done = 1'b0; e_cs = 1'b0; e_plot = 1'b0;
      e_x = '0; e_y = '0; e_col = 3'b000;
    end
    return {e_done, e_cs, m_colour, m_cx, m_cy, m_r, e_x, e_y, e_col, e_plot};
  endfunction

  task automatic checkOutput();
    logic [46:0] act, req;
    act = {dif.done, dif.circ_start, dif.circ_colour, dif.circ_centre_x,
           dif.circ_centre_y, dif.circ_radius, dif.vga_x, dif.vga_y,
           dif.vga_colour, dif.vga_plot};
    req = expected_outputs();
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL cycle_compare t=%0t phase=%0d actual=%h required=%h",
               $time, m_phase, act, req);
    end
  endtask

  task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput();
      if (rst_n && dif.vga_plot && !dif.circ_start) clear_plots++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] col,
                               input logic [7:0] x, input logic [6:0] y,
                               input logic [7:0] r);
    dif.start = s; dif.colour = col;
    dif.centre_x = x; dif.centre_y = y; dif.radius = r;
  endtask

  task automatic randomize_stub();
    dif.circ_x = 8'($urandom); dif.circ_y = 7'($urandom);
    dif.circ_colour_in = 3'($urandom); dif.circ_plot = 1'($urandom);
  endtask

  // Random traffic on every input until one full request has come back to idle.
  task automatic run_random();
    bit seen_done = 1'b0;
    bit finished  = 1'b0;
    for (int c = 0; c < 25000 && !finished; c++) begin
      tick();
      randomize_stub();
      dif.colour = 3'($urandom); dif.centre_x = 8'($urandom);
      dif.centre_y = 7'($urandom); dif.radius = 8'($urandom);
      case (m_phase)
        0: begin
             if (seen_done) finished = 1'b1;
             dif.start = 1'($urandom); dif.circ_done = 1'($urandom);
           end
        1: begin dif.start = 1'($urandom); dif.circ_done = 1'($urandom); end
        2: begin dif.start = 1'($urandom); dif.circ_done = ($urandom_range(0, 15) == 0); end
        default: begin
             seen_done = 1'b1;
             dif.circ_done = 1'($urandom);
             dif.start = ($urandom_range(0, 3) != 0);
           end
      endcase
    end
    dif.start = 1'b0;
    dif.circ_done = 1'b0;
    expect_lit("random_sequence_completes", 32'(finished), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'b000, 8'd0, 7'd0, 8'd0);
    dif.circ_done = 1'b0;
    dif.circ_x = '0; dif.circ_y = '0; dif.circ_colour_in = '0; dif.circ_plot = 1'b0;
    repeat (3) tick();
    check_en = 1'b1;
    @(negedge clk);
    expect_lit("reset_done", 32'(dif.done), 32'd0);
    expect_lit("reset_circ_start", 32'(dif.circ_start), 32'd0);
    expect_lit("reset_vga_plot", 32'(dif.vga_plot), 32'd0);
    expect_lit("reset_vga_colour", 32'(dif.vga_colour), 32'd0);

    // Directed request: clear, ignored start/colour/circ_done noise, circle, done.
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'b001, 8'd80, 7'd60, 8'd10);
    clear_plots = 0;
    tick();
    @(negedge clk);
    expect_lit("first_clear_x", 32'(dif.vga_x), 32'd0);
    expect_lit("first_clear_y", 32'(dif.vga_y), 32'd0);
    expect_lit("first_clear_colour", 32'(dif.vga_colour), 32'd0);
    expect_lit("first_clear_plot", 32'(dif.vga_plot), 32'd1);
    expect_lit("latched_radius", 32'(dif.circ_radius), 32'd10);
    for (int k = 1; k < SCREEN_PIXELS; k++) begin
      tick();
      randomize_stub();
      if (k == 5000) applyStimulus(1'b0, 3'b101, 8'd80, 7'd60, 8'd10);
      if (k == 5001) dif.start = 1'b1;
      if (k == 5003) dif.start = 1'b0;
      dif.circ_done = (k >= 9000 && k < 9010);
    end
    @(negedge clk);
    expect_lit("last_clear_x", 32'(dif.vga_x), 32'd159);
    expect_lit("last_clear_y", 32'(dif.vga_y), 32'd119);
    tick();
    dif.circ_x = 8'd90; dif.circ_y = 7'd60; dif.circ_colour_in = 3'b001; dif.circ_plot = 1'b1;
    dif.start = 1'b1;
    @(negedge clk);
    expect_lit("circ_start_cycle_19201", 32'(dif.circ_start), 32'd1);
    expect_lit("clear_plot_count", 32'(clear_plots), 32'd19200);
    expect_lit("circ_colour_kept", 32'(dif.circ_colour), 32'd1);
    expect_lit("circle_vga_x", 32'(dif.vga_x), 32'd90);
    expect_lit("circle_vga_y", 32'(dif.vga_y), 32'd60);
    expect_lit("circle_vga_colour", 32'(dif.vga_colour), 32'd1);
    expect_lit("circle_vga_plot", 32'(dif.vga_plot), 32'd1);
    repeat (3) begin tick(); randomize_stub(); end
    tick();
    dif.circ_done = 1'b1;
    tick();
    dif.circ_done = 1'b0;
    @(negedge clk);
    expect_lit("done_asserted", 32'(dif.done), 32'd1);
    expect_lit("done_circ_start", 32'(dif.circ_start), 32'd0);
    expect_lit("done_vga_plot", 32'(dif.vga_plot), 32'd0);
    repeat (4) begin
      tick();
      @(negedge clk);
      expect_lit("done_held", 32'(dif.done), 32'd1);
    end
    #1 dif.start = 1'b0;
    tick();
    @(negedge clk);
    expect_lit("back_to_idle_done", 32'(dif.done), 32'd0);
    expect_lit("back_to_idle_vga_plot", 32'(dif.vga_plot), 32'd0);

    // Reset in the middle of the clear scan at pixel (40,7).
    tick();
    applyStimulus(1'b1, 3'(1 + $urandom_range(0, 6)), 8'($urandom), 7'($urandom), 8'(1 + $urandom_range(0, 200)));
    clear_plots = 0;
    tick();
    dif.start = 1'b0;
    repeat (40 * 120 + 7) tick();
    @(negedge clk);
    expect_lit("pre_reset_x", 32'(dif.vga_x), 32'd40);
    expect_lit("pre_reset_y", 32'(dif.vga_y), 32'd7);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    expect_lit("post_reset_done", 32'(dif.done), 32'd0);
    expect_lit("post_reset_circ_start", 32'(dif.circ_start), 32'd0);
    expect_lit("post_reset_vga_x", 32'(dif.vga_x), 32'd0);
    expect_lit("post_reset_vga_y", 32'(dif.vga_y), 32'd0);
    expect_lit("post_reset_vga_colour", 32'(dif.vga_colour), 32'd0);
    expect_lit("post_reset_vga_plot", 32'(dif.vga_plot), 32'd0);
    expect_lit("post_reset_radius", 32'(dif.circ_radius), 32'd0);
    tick();
    applyStimulus(1'b1, 3'b110, 8'd33, 7'd44, 8'd5);
    tick();
    @(negedge clk);
    expect_lit("restart_x", 32'(dif.vga_x), 32'd0);
    expect_lit("restart_y", 32'(dif.vga_y), 32'd0);
    expect_lit("restart_plot", 32'(dif.vga_plot), 32'd1);
    run_random();

    // A second fully random request from idle.
    run_random();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001: One clock; reset is synchronous and active-low.
REQ-002: clk  in  1  system clock; all state changes on rising edge.
REQ-003: rst_n  in  1  synchronous active-low reset.
REQ-004: start  in  1  request: clear screen, then draw one circle.
REQ-005: done  out  1  high in DONE state only.
REQ-006: colour  in  3  circle colour, latched on accepted start.
REQ-007: centre_x  in  8  circle centre x, latched on accepted start.
REQ-008: centre_y  in  7  circle centre y, latched on accepted start.
REQ-009: radius  in  8  circle radius, latched on accepted start.
REQ-010: circ_start  out  1  start to downstream circle drawer.
REQ-011: circ_colour/circ_centre_x/circ_centre_y/circ_radius  out  3/8/7/8  latched parameters to circle drawer.
REQ-012: circ_done  in  1  circle drawer done.
REQ-013: circ_x/circ_y/circ_colour_in/circ_plot  in  8/7/3/1  circle drawer pixel outputs.
REQ-014: vga_x/vga_y/vga_colour/vga_plot  out  8/7/3/1  muxed pixel stream to VGA adapter.

Function
REQ-015: FSM states IDLE, CLEAR, CIRCLE, DONE; encoding free.
REQ-016: IDLE: start=1 at an edge -> latch colour/centre_x/centre_y/radius, zero clear counters, enter CLEAR; start=0 -> stay.
REQ-017: CLEAR: counters cx (0..159) outer, cy (0..119) inner; cy increments every cycle, wraps 119->0 with cx+1.
REQ-018: CLEAR outputs (combinational from counters): vga_x=cx, vga_y=cy, vga_colour=000, vga_plot=1.
REQ-019: CLEAR lasts exactly 19200 cycles; pixel (159,119) is last; the next edge enters CIRCLE.
REQ-020: CIRCLE: circ_start=1; vga_x/vga_y/vga_colour/vga_plot pass circ_x/circ_y/circ_colour_in/circ_plot through, zero latency.
REQ-021: CIRCLE: circ_done=1 at an edge -> DONE.
REQ-022: DONE: done=1, circ_start=0, vga_plot=0; start=0 at an edge -> IDLE; start=1 -> stay.
REQ-023: circ_start=0 in IDLE, CLEAR, DONE.
REQ-024: circ_colour/circ_centre_x/circ_centre_y/circ_radius always drive the latched registers; they change only on accepted start.
REQ-025: start changes during CLEAR or CIRCLE are ignored; the sequence always completes.
REQ-026: circ_done=1 during IDLE or CLEAR has no effect.
REQ-027: IDLE and DONE: vga_x=0, vga_y=0, vga_colour=latched colour, vga_plot=0.
REQ-028: Counter arithmetic is unsigned; cx never exceeds 159 and cy never exceeds 119.

Reset
REQ-029: rst_n=0 at an edge -> IDLE, cx=cy=0, latched params=0, from any state including mid-CLEAR/CIRCLE.
REQ-030: During and after reset: done=0, circ_start=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=000.
REQ-031: Reset has priority over start.

Verification
REQ-032: Reset, then start=1, colour=001, centre (80,60), r=10 -> first CLEAR cycle vga (0,0,000,plot=1); 19200 plot cycles, last (159,119); circ_start=1 on cycle 19201; circ_radius=10.
REQ-033: In CIRCLE, stub drives circ_x=90, circ_y=60, colour=001, plot=1 -> vga outputs identical in the same cycle.
REQ-034: Stub asserts circ_done with start held 1 -> next cycle done=1, circ_start=0, vga_plot=0; done stays 1 for 5 cycles; start=0 -> IDLE, done=0.
REQ-035: Change colour to 101 mid-CLEAR and toggle start -> circ_colour stays 001; plot count still 19200.
REQ-036: rst_n=0 at CLEAR pixel (40,7) -> next cycle IDLE, all outputs 0; new start restarts clear at (0,0).
REQ-037: circ_done=1 forced during CLEAR -> no early exit; CIRCLE still entered after exactly 19200 cycles.
